// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - two-master round-robin bus arbiter with serial slave select
// Optional feature macro: BUS_ARBITER_TIMEOUT_EN (force-release of a stuck owner)
module bus_arbiter #(
  parameter int SLAVE_LEN  = 2,
  parameter int NUM_SLAVES = 3,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  m1_request,
  input  logic                  m2_request,
  input  logic                  m1_slave_select,
  input  logic                  m2_slave_select,
  input  logic                  m1_done,
  input  logic                  m2_done,
  output logic                  arbitor_busy,
  output logic                  bus_busy,
  output logic                  m1_grant,
  output logic                  m2_grant,
  output logic                  bus_owner,
  output logic [NUM_SLAVES-1:0] slave_en,
  output logic                  select_error,
  output logic                  timeout
);

  localparam int CNT_W = $clog2(SLAVE_LEN) + 1;

  typedef enum logic [1:0] {IDLE, RX_SELECT, GRANT, BUSY} state_t;

  state_t                state_q, state_d;
  logic [SLAVE_LEN-1:0]  sel_q, sel_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  last_owner_q, last_owner_d;  // 1 = master 2 held the bus last
  logic                  bus_owner_q, bus_owner_d;
  logic                  arbitor_busy_q, arbitor_busy_d;
  logic                  bus_busy_q, bus_busy_d;
  logic                  m1_grant_q, m1_grant_d;
  logic                  m2_grant_q, m2_grant_d;
  logic [NUM_SLAVES-1:0] slave_en_q, slave_en_d;
  logic                  select_error_q, select_error_d;

  logic winner;
  logic owner_req;
  logic owner_sel;
  logic owner_done;
  logic idx_ok;
  logic tmo_expire;

  // Tie goes to the master that did not own the bus last; a lone requester always wins.
  assign winner     = m2_request & (~m1_request | ~last_owner_q);
  assign owner_req  = bus_owner_q ? m2_request      : m1_request;
  assign owner_sel  = bus_owner_q ? m2_slave_select : m1_slave_select;
  assign owner_done = bus_owner_q ? m2_done         : m1_done;
  assign idx_ok     = 32'(sel_q) < NUM_SLAVES;

  // Next-state and registered-output computation.
  always_comb begin
    state_d        = state_q;
    sel_d          = sel_q;
    cnt_d          = cnt_q;
    last_owner_d   = last_owner_q;
    bus_owner_d    = bus_owner_q;
    slave_en_d     = slave_en_q;
    m1_grant_d     = 1'b0;
    m2_grant_d     = 1'b0;
    select_error_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (m1_request || m2_request) begin
          bus_owner_d = winner;
          sel_d       = '0;
          sel_d[0]    = winner ? m2_slave_select : m1_slave_select;
          cnt_d       = CNT_W'(1);
          state_d     = (SLAVE_LEN == 1) ? GRANT : RX_SELECT;
        end
      end
      RX_SELECT: begin
        if (!owner_req) begin
          state_d = IDLE;
        end else begin
          for (int i = 1; i < SLAVE_LEN; i++) begin
            if (CNT_W'(i) == cnt_q) sel_d[i] = owner_sel;
          end
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(SLAVE_LEN - 1)) state_d = GRANT;
        end
      end
      GRANT: begin
        if (idx_ok) begin
          state_d    = BUSY;
          m1_grant_d = ~bus_owner_q;
          m2_grant_d = bus_owner_q;
          for (int i = 0; i < NUM_SLAVES; i++) begin
            slave_en_d[i] = (32'(sel_q) == 32'(i));
          end
        end else begin
          state_d        = IDLE;
          select_error_d = 1'b1;
          slave_en_d     = '0;
        end
      end
      BUSY: begin
        if (owner_done || tmo_expire) begin
          state_d      = IDLE;
          slave_en_d   = '0;
          last_owner_d = bus_owner_q;
        end
      end
      default: state_d = IDLE;
    endcase
    arbitor_busy_d = (state_d == RX_SELECT) || (state_d == GRANT);
    bus_busy_d     = (state_d == BUSY);
  end

  // State and output registers; reset leaves master 1 favoured on the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      sel_q          <= '0;
      cnt_q          <= '0;
      last_owner_q   <= 1'b1;
      bus_owner_q    <= 1'b0;
      arbitor_busy_q <= 1'b0;
      bus_busy_q     <= 1'b0;
      m1_grant_q     <= 1'b0;
      m2_grant_q     <= 1'b0;
      slave_en_q     <= '0;
      select_error_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      sel_q          <= sel_d;
      cnt_q          <= cnt_d;
      last_owner_q   <= last_owner_d;
      bus_owner_q    <= bus_owner_d;
      arbitor_busy_q <= arbitor_busy_d;
      bus_busy_q     <= bus_busy_d;
      m1_grant_q     <= m1_grant_d;
      m2_grant_q     <= m2_grant_d;
      slave_en_q     <= slave_en_d;
      select_error_q <= select_error_d;
    end
  end

`ifdef BUS_ARBITER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             timeout_q, timeout_d;

  assign tmo_expire = (state_q == BUSY) && (tmo_q == TMO_W'(TIMEOUT - 1)) && !owner_done;

  // Ownership age counter; restarts whenever the bus is not held.
  always_comb begin
    tmo_d     = (state_q == BUSY) ? tmo_q + TMO_W'(1) : '0;
    timeout_d = tmo_expire;
  end

  // Timeout counter and pulse registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      tmo_q     <= tmo_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign tmo_expire = 1'b0;
  // Timeout never fires in this build; the owner keeps the bus until done or reset.
  assign timeout    = (TIMEOUT < 0);
`endif

  assign arbitor_busy = arbitor_busy_q;
  assign bus_busy     = bus_busy_q;
  assign m1_grant     = m1_grant_q;
  assign m2_grant     = m2_grant_q;
  assign bus_owner    = bus_owner_q;
  assign slave_en     = slave_en_q;
  assign select_error = select_error_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - self-checking bench for bus_arbiter against a transaction-level model
module tb_bus_arbiter;

  localparam int SL  = 2;
  localparam int NS  = 3;
  localparam int TMO = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic          r1, r2, s1, s2, d1, d2;
  logic          arbitor_busy, bus_busy, m1_grant, m2_grant, bus_owner;
  logic [NS-1:0] slave_en;
  logic          select_error, timeout;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Model: a transaction is either being collected (m_active), or the bus is owned.
  bit m_active, m_owned, m_owner, m_last;
  int m_nbits, m_idx, m_cyc;
  bit e_g1, e_g2, e_err, e_tmo;
  int e_slave;

  bus_arbiter #(.SLAVE_LEN(SL), .NUM_SLAVES(NS), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .m1_request(r1), .m2_request(r2),
    .m1_slave_select(s1), .m2_slave_select(s2),
    .m1_done(d1), .m2_done(d2),
    .arbitor_busy(arbitor_busy), .bus_busy(bus_busy),
    .m1_grant(m1_grant), .m2_grant(m2_grant),
    .bus_owner(bus_owner), .slave_en(slave_en),
    .select_error(select_error), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_owned = 0; m_owner = 0; m_last = 1;
    m_nbits = 0; m_idx = 0; m_cyc = 0;
    e_g1 = 0; e_g2 = 0; e_err = 0; e_tmo = 0; e_slave = 0;
  endtask

  task automatic model_step();
    bit done, expire;
    e_g1 = 0; e_g2 = 0; e_err = 0; e_tmo = 0;
    if (m_owned) begin
      done   = m_owner ? d2 : d1;
      expire = 0;
`ifdef BUS_ARBITER_TIMEOUT_EN
      expire = (m_cyc == TMO - 1) && !done;
`endif
      if (done || expire) begin
        m_owned = 0; m_last = m_owner; e_slave = 0; e_tmo = expire;
      end else begin
        m_cyc++;
      end
    end else if (m_active) begin
      if (m_nbits < SL) begin
        if (!(m_owner ? r2 : r1)) m_active = 0;
        else begin
          m_idx += (m_owner ? int'(s2) : int'(s1)) << m_nbits;
          m_nbits++;
        end
      end else begin
        m_active = 0;
        if (m_idx < NS) begin
          m_owned = 1; m_cyc = 0; e_slave = 1 << m_idx;
          if (m_owner) e_g2 = 1; else e_g1 = 1;
        end else begin
          e_err = 1;
        end
      end
    end else if (r1 || r2) begin
      m_owner  = (r1 && r2) ? !m_last : r2;
      m_active = 1;
      m_idx    = m_owner ? int'(s2) : int'(s1);
      m_nbits  = 1;
    end
  endtask

  task automatic check_all();
    check("arbitor_busy", 32'(arbitor_busy), 32'(m_active));
    check("bus_busy",     32'(bus_busy),     32'(m_owned));
    check("m1_grant",     32'(m1_grant),     32'(e_g1));
    check("m2_grant",     32'(m2_grant),     32'(e_g2));
    check("bus_owner",    32'(bus_owner),    32'(m_owner));
    check("slave_en",     32'(slave_en),     32'(e_slave));
    check("select_error", 32'(select_error), 32'(e_err));
    check("timeout",      32'(timeout),      32'(e_tmo));
  endtask

  task automatic cyc();
    @(posedge clk);
    if (reset) model_reset(); else model_step();
    #1;
    check_all();
  endtask

  initial begin
    reset = 1; r1 = 0; r2 = 0; s1 = 0; s2 = 0; d1 = 0; d2 = 0;
    model_reset();
    cyc();
    check("reset_bus_busy", 32'(bus_busy), 32'd0);
    check("reset_slave_en", 32'(slave_en), 32'd0);
    reset = 0;
    cyc();

    // m1 addresses slave 2 (bits 0,1): grant on the third cycle
    r1 = 1; s1 = 0; cyc();
    s1 = 1; cyc();
    check("m1_no_early_grant", 32'(m1_grant), 32'd0);
    r1 = 0; s1 = 0; cyc();
    check("m1_grant_cycle3", 32'(m1_grant), 32'd1);
    check("m1_slave_en", 32'(slave_en), 32'b100);
    check("m1_owner", 32'(bus_owner), 32'd0);
    d1 = 1; cyc(); d1 = 0;
    check("m1_release", 32'(bus_busy), 32'd0);

    // Round robin from reset: m1 then m2
    reset = 1; cyc(); reset = 0;
    r1 = 1; r2 = 1; cyc(); cyc();
    r1 = 0; r2 = 0; cyc();
    check("rr_first_m1", 32'(m1_grant), 32'd1);
    check("rr_first_owner", 32'(bus_owner), 32'd0);
    d1 = 1; cyc(); d1 = 0;
    r1 = 1; r2 = 1; cyc(); cyc();
    r1 = 0; r2 = 0; cyc();
    check("rr_second_m2", 32'(m2_grant), 32'd1);
    check("rr_second_owner", 32'(bus_owner), 32'd1);
    check("rr_second_slave", 32'(slave_en), 32'b001);
    d2 = 1; cyc(); d2 = 0;

    // m2 sends index 3: select error, no grant
    r2 = 1; s2 = 1; cyc(); cyc();
    r2 = 0; s2 = 0; cyc();
    check("err_pulse", 32'(select_error), 32'd1);
    check("err_no_grant", 32'(m2_grant), 32'd0);
    check("err_slave_en", 32'(slave_en), 32'd0);
    check("err_idle", 32'(arbitor_busy | bus_busy), 32'd0);

    // Non-owner done ignored; owner request drop aborts collection
    r1 = 1; cyc(); cyc(); r1 = 0; cyc();
    d2 = 1; cyc(); d2 = 0;
    check("foreign_done_held", 32'(bus_busy), 32'd1);
    d1 = 1; cyc(); d1 = 0;
    r1 = 1; cyc();
    check("abort_rx", 32'(arbitor_busy), 32'd1);
    r1 = 0; cyc();
    check("abort_idle", 32'(arbitor_busy), 32'd0);
    cyc();
    check("abort_no_grant", 32'(m1_grant | bus_busy), 32'd0);

    // Asynchronous reset in BUSY
    r1 = 1; cyc(); cyc(); r1 = 0; cyc();
    #2 reset = 1; #1;
    model_reset();
    check("async_bus_busy", 32'(bus_busy), 32'd0);
    check("async_slave_en", 32'(slave_en), 32'd0);
    check_all();
    cyc(); reset = 0;
    r2 = 1; cyc(); cyc(); r2 = 0; cyc();
    check("post_reset_m2", 32'(m2_grant), 32'd1);
    d2 = 1; cyc(); d2 = 0;

    // Long ownership with no done
    r1 = 1; cyc(); cyc(); r1 = 0; cyc();
    for (int k = 1; k < TMO; k++) cyc();
    check("hold_before_tmo", 32'(bus_busy), 32'd1);
    cyc();
`ifdef BUS_ARBITER_TIMEOUT_EN
    check("tmo_pulse", 32'(timeout), 32'd1);
    check("tmo_release", 32'(bus_busy), 32'd0);
`else
    check("no_tmo_pulse", 32'(timeout), 32'd0);
    check("no_tmo_hold", 32'(bus_busy), 32'd1);
    d1 = 1; cyc(); d1 = 0;
`endif

    // Randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 7) == 0) r1 = ~r1;
      if ($urandom_range(0, 7) == 0) r2 = ~r2;
      s1 = 1'($urandom);
      s2 = 1'($urandom);
      d1 = ($urandom_range(0, 11) == 0);
      d2 = ($urandom_range(0, 11) == 0);
      reset = ($urandom_range(0, 199) == 0);
      cyc();
    end
    reset = 0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
